// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package muldiv_pkg;
  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  localparam int MD_ITERS = 32;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX
  } md_state_t;
endpackage

// File: rtl/ex_muldiv_core.sv
// One iteration on the shared 64-bit accumulator: a radix-2 shift-add step for
// multiply, or a restoring-subtract step on {remainder, quotient} for divide.
module ex_muldiv_core (
  input  logic [63:0] acc,
  input  logic [31:0] opnd_b,
  input  logic        is_div,
  output logic [63:0] acc_nxt
);
  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [31:0] sub;
  logic        ge;

  always_comb begin
    // Multiply: high half accumulates, multiplier bits drain out of the low half.
    sum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_b} : 33'd0);
    // Divide: the remainder is always below the divisor, so a 32-bit difference suffices.
    rem_sh = acc[63:31];
    ge     = (rem_sh >= {1'b0, opnd_b});
    sub    = rem_sh[31:0] - opnd_b;
    if (is_div)
      acc_nxt = ge ? {sub, acc[30:0], 1'b1} : {rem_sh[31:0], acc[30:0], 1'b0};
    else
      acc_nxt = {sum, acc[31:1]};
  end
endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; magnitudes are iterated
// for 32 cycles and the sign is restored in a final FIX cycle.
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  md_state_t   state, state_nxt;
  logic [5:0]  cnt;
  logic [63:0] acc, acc_nxt;
  logic [31:0] mag_b, a_raw;
  logic [1:0]  op_q;
  logic        neg_q, rem_neg_q, div0_q;

  logic        is_signed, is_div_q;
  logic [31:0] mag_a_in, mag_b_in;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
  assign mag_a_in  = (is_signed && src_a[31]) ? -src_a : src_a;
  assign mag_b_in  = (is_signed && src_b[31]) ? -src_b : src_b;
  assign is_div_q  = (op_q == MD_DIV) || (op_q == MD_DIVU);
  assign busy      = (state != MD_IDLE);

  ex_muldiv_core u_core (
    .acc    (acc),
    .opnd_b (mag_b),
    .is_div (is_div_q),
    .acc_nxt(acc_nxt)
  );

  // Divide by zero still runs the full iteration count; FIX substitutes the fixed result.
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = div0_q ? 32'hFFFF_FFFF : (neg_q ? -acc[31:0] : acc[31:0]);
    rem_fix  = div0_q ? a_raw : (rem_neg_q ? -acc[63:32] : acc[63:32]);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (start && !flush) state_nxt = MD_CALC;
      MD_CALC: begin
        if (flush)                            state_nxt = MD_IDLE;
        else if (cnt == 6'(MD_ITERS - 1))     state_nxt = MD_FIX;
      end
      MD_FIX:  state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MD_IDLE;
      cnt       <= '0;
      acc       <= '0;
      mag_b     <= '0;
      a_raw     <= '0;
      op_q      <= MD_MULT;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == MD_FIX);
      case (state)
        MD_IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start && !flush) begin
            op_q      <= op;
            neg_q     <= is_signed && (src_a[31] ^ src_b[31]);
            rem_neg_q <= is_signed && src_a[31];
            div0_q    <= (src_b == 32'd0);
            a_raw     <= src_a;
            mag_b     <= mag_b_in;
            acc       <= {32'd0, mag_a_in};
            cnt       <= '0;
          end
        end
        MD_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 6'd1;
        end
        MD_FIX: begin
          if (is_div_q) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed checks of ex_muldiv: arithmetic results, latency, busy/done shape,
// flush, async reset and writes ignored while busy.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic        start = 1'b0, flush = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src_a = '0, src_b = '0, wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    step();
    start = 1'b0; op = ~o; src_a = ~a; src_b = 32'h5A5A_5A5A;
  endtask

  task automatic wait_done(output int waited, output int bcnt);
    waited = 0; bcnt = 0;
    while (!done && waited < 60) begin
      if (busy) bcnt++;
      step();
      waited++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int w, bc;
    issue(o, a, b);
    wait_done(w, bc);
    chk({tag, " latency"}, w, 33);
    chk({tag, " busy cycles"}, bc, 33);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
  endtask

  initial begin
    int w, bc, seen;
    #7;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    rst = 1'b0;
    step();

    run("mult -3*7", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    step();
    chk("mult done width", done, 0);
    chk("mult busy after", busy, 0);

    run("multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run("div min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run("div -5/0", MD_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run("divu 100/0", MD_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run("divu b2b 100/7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    // start with flush in IDLE is dropped
    step();
    start = 1'b1; flush = 1'b1; op = MD_MULTU; src_a = 32'd3; src_b = 32'd3;
    step();
    start = 1'b0; flush = 1'b0;
    chk("flush+start busy", busy, 0);
    step();
    chk("flush+start lo", lo, 32'd14);

    // flush mid-CALC after MTHI
    mthi = 1'b1; wdata = 32'h0000_1234;
    step();
    mthi = 1'b0;
    chk("mthi hi", hi, 32'h0000_1234);
    issue(MD_MULTU, 32'd5, 32'd5);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush busy drop", busy, 0);
    seen = 0;
    repeat (40) begin
      if (done) seen++;
      step();
    end
    chk("flush no done", seen, 0);
    chk("flush hi kept", hi, 32'h0000_1234);
    chk("flush lo kept", lo, 32'd14);

    // MTHI with start is overwritten; start/MTLO/MTHI while busy are ignored
    mthi = 1'b1; wdata = 32'h0000_AAAA;
    issue(MD_MULT, 32'd6, 32'd7);
    mthi = 1'b0;
    repeat (4) step();
    start = 1'b1; op = MD_MULTU; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
    mtlo = 1'b1; mthi = 1'b1; wdata = 32'h0000_DEAD;
    step();
    start = 1'b0; mtlo = 1'b0; mthi = 1'b0;
    wait_done(w, bc);
    chk("busy writes done seen", done, 1);
    chk("busy writes hi", hi, 32'd0);
    chk("busy writes lo", lo, 32'd42);
    step();
    chk("ignored start busy", busy, 0);

    // async reset between edges mid-CALC
    issue(MD_MULTU, 32'd3, 32'd3);
    repeat (5) step();
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst done", done, 0);
    chk("async rst hi", hi, 0);
    chk("async rst lo", lo, 0);
    #1 rst = 1'b0;
    step();
    chk("post rst idle", busy, 0);
    run("post rst multu 3*3", MD_MULTU, 32'd3, 32'd3, 32'd0, 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
